trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 145 ++++++++++++++
 tb/tb_trap_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
//----------------------------------------------------------------------------
// Module      : trap_ctrl
// Description : Machine-mode trap/MRET sequencer with fetch-redirect handshake
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module trap_ctrl #(
  parameter int VECTOR_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid_wb,
  input  logic [31:0] pc_wb,
  input  logic        exc_fetch_misalign,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        mret_wb,
  input  logic        extern_intr,
  input  logic        timer_intr,
  input  logic        software_intr,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [1:0]  privilege_mode,
  output logic        mcause_update,
  output logic [5:0]  mcause,
  output logic        is_mret,
  output logic        kill_wb,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [1:0] c_PRIV_U = 2'b00;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;

  logic        w_accept;
  logic        w_is_u;
  logic        w_exc;
  logic [4:0]  w_exc_code;
  logic [2:0]  w_pend;
  logic        w_intr;
  logic [4:0]  w_intr_code;
  logic        w_take_trap;
  logic        w_take_mret;
  logic        w_trap_is_intr;
  logic [4:0]  w_code;
  logic [31:0] w_base;
  logic [31:0] w_target;
  logic        w_unused_mie;

  assign w_unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0], pc_wb};

  assign w_accept = reset_n && (r_state == IDLE) && instr_valid_wb;
  assign w_is_u   = (privilege_mode == c_PRIV_U);
  assign w_pend   = {extern_intr & mie[11], software_intr & mie[3], timer_intr & mie[7]};
  assign w_intr   = (|w_pend) && (mstatus_mie || w_is_u);
  assign w_base   = {mtvec[31:2], 2'b00};

  // MRET from user mode is reported as an illegal instruction.
  always_comb begin
    w_exc      = 1'b1;
    w_exc_code = 5'd0;
    if (exc_fetch_misalign) begin
      w_exc_code = 5'd0;
    end else if (exc_illegal || (mret_wb && w_is_u)) begin
      w_exc_code = 5'd2;
    end else if (exc_ebreak) begin
      w_exc_code = 5'd3;
    end else if (exc_ecall) begin
      w_exc_code = w_is_u ? 5'd8 : 5'd11;
    end else begin
      w_exc = 1'b0;
    end
  end

  always_comb begin
    w_intr_code = 5'd7;
    if (w_pend[2]) begin
      w_intr_code = 5'd11;
    end else if (w_pend[1]) begin
      w_intr_code = 5'd3;
    end
  end

  assign w_take_trap    = w_accept && (w_exc || w_intr);
  assign w_trap_is_intr = !w_exc && w_intr;
  assign w_take_mret    = w_accept && mret_wb && !w_exc && !w_intr;
  assign w_code         = w_trap_is_intr ? w_intr_code : w_exc_code;

  // Vectored mode offsets interrupts only; exceptions always land on the base.
  always_comb begin
    w_target = w_base;
    if (w_take_mret) begin
      w_target = mepc;
    end else if ((VECTOR_EN != 0) && (mtvec[1:0] == 2'b01) && w_trap_is_intr) begin
      w_target = w_base + {25'd0, w_code, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take_trap || w_take_mret) begin
            r_state          <= REDIRECT;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_target;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign mcause_update  = w_take_trap;
  assign mcause         = w_take_trap ? {w_trap_is_intr, w_code} : 6'd0;
  assign is_mret        = w_take_mret;
  assign kill_wb        = reset_n && ((r_state == REDIRECT) || w_take_trap);
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
//----------------------------------------------------------------------------
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid_wb;
  logic [31:0] pc_wb;
  logic        exc_fetch_misalign, exc_illegal, exc_ebreak, exc_ecall, mret_wb;
  logic        extern_intr, timer_intr, software_intr, mstatus_mie;
  logic [31:0] mie, mtvec, mepc;
  logic [1:0]  privilege_mode;
  logic        mcause_update;
  logic [5:0]  mcause;
  logic        is_mret, kill_wb, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.VECTOR_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid_wb(instr_valid_wb), .pc_wb(pc_wb),
    .exc_fetch_misalign(exc_fetch_misalign), .exc_illegal(exc_illegal),
    .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall), .mret_wb(mret_wb),
    .extern_intr(extern_intr), .timer_intr(timer_intr), .software_intr(software_intr),
    .mstatus_mie(mstatus_mie), .mie(mie), .mtvec(mtvec), .mepc(mepc),
    .privilege_mode(privilege_mode), .mcause_update(mcause_update), .mcause(mcause),
    .is_mret(is_mret), .kill_wb(kill_wb), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    instr_valid_wb = 0; pc_wb = 32'h100;
    exc_fetch_misalign = 0; exc_illegal = 0; exc_ebreak = 0; exc_ecall = 0; mret_wb = 0;
    extern_intr = 0; timer_intr = 0; software_intr = 0; mstatus_mie = 1;
    mie = 32'h0; mtvec = 32'h200; mepc = 32'h0; privilege_mode = 2'b11;
    redirect_ready = 0;
  endtask

  // Trap outputs in the accept cycle, then redirect target one edge later.
  task automatic trap_chk(input string tag, input logic [5:0] cause, input logic [31:0] tgt);
    #1;
    chk({tag, "_upd"}, {31'd0, mcause_update}, 32'd1);
    chk({tag, "_cause"}, {26'd0, mcause}, {26'd0, cause});
    chk({tag, "_kill"}, {31'd0, kill_wb}, 32'd1);
    tick();
    chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd1);
    chk({tag, "_rpc"}, redirect_pc, tgt);
  endtask

  task automatic ack();
    clr();
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    chk("ack_rv", {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    clr();
    reset_n = 0;
    instr_valid_wb = 1; exc_ecall = 1;
    #2;
    chk("rst_upd", {31'd0, mcause_update}, 32'd0);
    chk("rst_kill", {31'd0, kill_wb}, 32'd0);
    tick();
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    reset_n = 1; clr();

    // ready in IDLE is ignored
    redirect_ready = 1;
    tick();
    chk("idle_ready", {31'd0, redirect_valid}, 32'd0);

    clr(); instr_valid_wb = 1; exc_ecall = 1;
    trap_chk("ecall_m", 6'h0B, 32'h200);
    ack();

    clr(); instr_valid_wb = 1; timer_intr = 1; mie = 32'h80; mtvec = 32'h201;
    trap_chk("vec_timer", 6'h27, 32'h21C);
    ack();

    clr(); instr_valid_wb = 1; timer_intr = 1; mie = 32'h80; mtvec = 32'h200;
    trap_chk("direct_timer", 6'h27, 32'h200);
    ack();

    clr(); instr_valid_wb = 1; extern_intr = 1; software_intr = 1; timer_intr = 1;
    mie = 32'h888; mtvec = 32'hFFFF_FFF1;
    trap_chk("vec_wrap_ext", 6'h2B, 32'h0000_001C);
    ack();

    clr(); instr_valid_wb = 1; software_intr = 1; timer_intr = 1; mie = 32'h88;
    mstatus_mie = 0; privilege_mode = 2'b00; mtvec = 32'h301;
    trap_chk("u_sw", 6'h23, 32'h30C);
    ack();

    clr(); instr_valid_wb = 1; exc_illegal = 1; extern_intr = 1; mie = 32'h800; mtvec = 32'h201;
    trap_chk("ill_vs_ext", 6'h02, 32'h200);
    ack();

    clr(); instr_valid_wb = 1; extern_intr = 1; mie = 32'h800; mstatus_mie = 0;
    #1;
    chk("masked_upd", {31'd0, mcause_update}, 32'd0);
    chk("masked_kill", {31'd0, kill_wb}, 32'd0);
    exc_illegal = 1;
    trap_chk("masked_ill", 6'h02, 32'h200);
    ack();

    clr(); instr_valid_wb = 1; exc_fetch_misalign = 1; exc_ebreak = 1; exc_ecall = 1;
    trap_chk("misalign_pri", 6'h00, 32'h200);
    ack();

    clr(); instr_valid_wb = 1; exc_ebreak = 1; exc_ecall = 1;
    trap_chk("ebreak_pri", 6'h03, 32'h200);
    ack();

    clr(); instr_valid_wb = 1; exc_ecall = 1; privilege_mode = 2'b00;
    trap_chk("ecall_u", 6'h08, 32'h200);
    ack();

    clr(); instr_valid_wb = 1; mret_wb = 1; mepc = 32'h400;
    #1;
    chk("mret_pulse", {31'd0, is_mret}, 32'd1);
    chk("mret_kill", {31'd0, kill_wb}, 32'd0);
    chk("mret_upd", {31'd0, mcause_update}, 32'd0);
    tick();
    chk("mret_rpc", redirect_pc, 32'h400);
    chk("mret_rv", {31'd0, redirect_valid}, 32'd1);
    ack();

    clr(); instr_valid_wb = 1; mret_wb = 1; mepc = 32'h400; timer_intr = 1; mie = 32'h80;
    #1;
    chk("mret_vs_int", {31'd0, is_mret}, 32'd0);
    trap_chk("mret_int", 6'h27, 32'h200);
    ack();

    clr(); instr_valid_wb = 1; mret_wb = 1; mepc = 32'h400; privilege_mode = 2'b00;
    #1;
    chk("mret_u_ism", {31'd0, is_mret}, 32'd0);
    trap_chk("mret_u", 6'h02, 32'h200);
    ack();

    // Hold redirect with ready low while ecall keeps being presented.
    clr(); instr_valid_wb = 1; exc_ecall = 1;
    trap_chk("hold", 6'h0B, 32'h200);
    mtvec = 32'h500;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_upd", {31'd0, mcause_update}, 32'd0);
      chk("hold_kill", {31'd0, kill_wb}, 32'd1);
      tick();
      chk("hold_rv", {31'd0, redirect_valid}, 32'd1);
      chk("hold_rpc", redirect_pc, 32'h200);
    end
    redirect_ready = 1;
    tick();
    chk("hold_done", {31'd0, redirect_valid}, 32'd0);
    redirect_ready = 0;
    trap_chk("hold_next", 6'h0B, 32'h500);

    // Reset while redirect is outstanding.
    clr(); reset_n = 0;
    #1;
    chk("rst_redir_kill", {31'd0, kill_wb}, 32'd0);
    tick();
    chk("rst_redir_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redir_rpc", redirect_pc, 32'd0);
    reset_n = 1;
    clr(); instr_valid_wb = 1; exc_ecall = 1;
    trap_chk("post_rst", 6'h0B, 32'h200);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
